tdm_frame_streamer: RTL and testbench

//  Sits directly downstream of the TDM receive master. Captures each complete TDM frame (flat NChannels*DataSize bus)

---
 rtl/tdm_frame_streamer_if.sv | 30 +++
 rtl/tdm_frame_streamer.sv | 156 +++++++++++++++
 tb/tb_tdm_frame_streamer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_frame_streamer_if.sv
// Per-channel sample stream carried out of the TDM frame streamer.
// The master drives samples, channel tags and valid; the slave returns ready.
interface tdm_frame_streamer_if #(
    parameter int DataSize  = 32,
    parameter int NChannels = 8
) ();
    localparam int ChanW = $clog2(NChannels) + 1;

    logic [DataSize-1:0] m_data_o;
    logic [ChanW-1:0]    m_chan_o;
    logic                m_last_o;
    logic                m_valid_o;
    logic                m_ready_i;

    modport master (
        output m_data_o,
        output m_chan_o,
        output m_last_o,
        output m_valid_o,
        input  m_ready_i
    );

    modport slave (
        input  m_data_o,
        input  m_chan_o,
        input  m_last_o,
        input  m_valid_o,
        output m_ready_i
    );
endinterface

// File: rtl/tdm_frame_streamer.sv
// Buffers whole TDM frames in a small FIFO and replays them one channel per
// handshake; frames arriving while the FIFO is full are dropped and counted.
module tdm_frame_streamer #(
    parameter int DataSize   = 32,
    parameter int NChannels  = 8,
    parameter int FrameDepth = 4,
    parameter int CntWidth   = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [DataSize*NChannels-1:0]   frame_data_i,
    input  logic                            frame_valid_i,
    tdm_frame_streamer_if.master            m_if,
    output logic [$clog2(FrameDepth):0]     level_o,
    output logic                            overflow_o,
    output logic [CntWidth-1:0]             drop_count_o
);
    localparam int FrameW = DataSize * NChannels;
    localparam int PtrW   = $clog2(FrameDepth);
    localparam int LvlW   = PtrW + 1;
    localparam int ChanW  = $clog2(NChannels) + 1;
    localparam logic [ChanW-1:0] LAST_CHAN = ChanW'(NChannels - 1);
    localparam logic [LvlW-1:0]  FULL_LVL  = LvlW'(FrameDepth);

    logic [FrameW-1:0]   mem_q [FrameDepth];
    logic [LvlW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LvlW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ChanW-1:0]    chan_q, chan_d;
    logic                fv_prev_q, fv_prev_d;
    logic                overflow_q, overflow_d;
    logic [CntWidth-1:0] drop_cnt_q, drop_cnt_d;

    logic [LvlW-1:0]     level_s;
    logic                valid_s;
    logic                last_s;
    logic                beat_s;
    logic                last_pop_s;
    logic                push_evt_s;
    logic                push_ok_s;
    logic                drop_s;
    logic [FrameW-1:0]   frame_s;
    logic [DataSize-1:0] sample_s;
    logic [DataSize-1:0] m_data_s;

    // Occupancy, handshake and push/drop decisions from registered state.
    always_comb begin
        level_s    = wr_ptr_q - rd_ptr_q;
        valid_s    = (level_s != {LvlW{1'b0}});
        last_s     = valid_s & (chan_q == LAST_CHAN);
        beat_s     = valid_s & m_if.m_ready_i;
        last_pop_s = beat_s & last_s;
        push_evt_s = frame_valid_i & ~fv_prev_q;
        // A full FIFO still takes the frame if the slot it frees retires on this edge.
        if (level_s < FULL_LVL) begin
            push_ok_s = push_evt_s;
        end else begin
            push_ok_s = push_evt_s & last_pop_s;
        end
        drop_s = push_evt_s & ~push_ok_s;
    end

    // Next-state: pointers, channel counter, edge detector and drop bookkeeping.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        chan_d     = chan_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        fv_prev_d  = frame_valid_i;

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + LvlW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (beat_s) begin
            if (last_s) begin
                chan_d   = {ChanW{1'b0}};
                rd_ptr_d = rd_ptr_q + LvlW'(1);
            end else begin
                chan_d   = chan_q + ChanW'(1);
                rd_ptr_d = rd_ptr_q;
            end
        end else begin
            chan_d   = chan_q;
            rd_ptr_d = rd_ptr_q;
        end

        if (drop_s) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {CntWidth{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + CntWidth'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= {LvlW{1'b0}};
            rd_ptr_q   <= {LvlW{1'b0}};
            chan_q     <= {ChanW{1'b0}};
            fv_prev_q  <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= {CntWidth{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            chan_q     <= chan_d;
            fv_prev_q  <= fv_prev_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Frame storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk_i) begin
        if (push_ok_s && !rst_i) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= frame_data_i;
        end else begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= mem_q[wr_ptr_q[PtrW-1:0]];
        end
    end

    // Output view: select the current channel of the head frame.
    always_comb begin
        frame_s  = mem_q[rd_ptr_q[PtrW-1:0]];
        sample_s = {DataSize{1'b0}};
        for (int c = 0; c < NChannels; c++) begin
            if (chan_q == ChanW'(c)) begin
                sample_s = frame_s[c*DataSize +: DataSize];
            end else begin
                sample_s = sample_s;
            end
        end
        if (valid_s) begin
            m_data_s = sample_s;
        end else begin
            m_data_s = {DataSize{1'b0}};
        end
    end

    assign m_if.m_data_o  = m_data_s;
    assign m_if.m_chan_o  = chan_q;
    assign m_if.m_last_o  = last_s;
    assign m_if.m_valid_o = valid_s;
    assign level_o        = level_s;
    assign overflow_o     = overflow_q;
    assign drop_count_o   = drop_cnt_q;
endmodule

// File: tb/tb_tdm_frame_streamer.sv
// Scoreboard bench for tdm_frame_streamer (8-bit samples, 4 channels, 4 frames).
module tb_tdm_frame_streamer;
    localparam int DS = 8;
    localparam int NC = 4;
    localparam int FD = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] chan;
        logic       last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     frame_data = 32'h0;
    logic            frame_valid = 1'b0;
    logic [2:0]      level;
    logic            overflow;
    logic [CW-1:0]   drop_count;

    int    checks = 0;
    int    errors = 0;
    int    outstanding = 0;
    beat_t exp_q[$];

    logic       stalled = 1'b0;
    logic [7:0] hold_data;
    logic [2:0] hold_chan;
    logic       hold_last;

    tdm_frame_streamer_if #(.DataSize(DS), .NChannels(NC)) sif ();

    tdm_frame_streamer #(.DataSize(DS), .NChannels(NC), .FrameDepth(FD), .CntWidth(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .frame_data_i (frame_data),
        .frame_valid_i(frame_valid),
        .m_if         (sif.master),
        .level_o      (level),
        .overflow_o   (overflow),
        .drop_count_o (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [31:0] f);
        beat_t b;
        logic [31:0] fv;
        fv = f;
        for (int c = 0; c < NC; c++) begin
            b.data = fv[c*8 +: 8];
            b.chan = 3'(c);
            b.last = (c == NC - 1);
            exp_q.push_back(b);
        end
        outstanding++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [31:0] f, input logic accepted);
        frame_valid = 1'b1;
        frame_data  = f;
        if (accepted) expect_frame(f);
        tick();
        frame_valid = 1'b0;
        tick();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        sif.m_ready_i = 1'b1;
        while ((exp_q.size() != 0 || sif.m_valid_o) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d beats still expected after 200 cycles", name, exp_q.size());
        end
    endtask

    // Monitor: compare every transferring beat against the scoreboard and check stall stability.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", 64'(sif.m_valid_o), 64'd1);
                check("hold_data", 64'(sif.m_data_o), 64'(hold_data));
                check("hold_chan", 64'(sif.m_chan_o), 64'(hold_chan));
                check("hold_last", 64'(sif.m_last_o), 64'(hold_last));
            end
            if (sif.m_valid_o && sif.m_ready_i) begin
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got data %0h chan %0d with nothing expected",
                             sif.m_data_o, sif.m_chan_o);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", 64'(sif.m_data_o), 64'(e.data));
                    check("beat_chan", 64'(sif.m_chan_o), 64'(e.chan));
                    check("beat_last", 64'(sif.m_last_o), 64'(e.last));
                    if (e.last) outstanding--;
                end
            end else if (sif.m_valid_o) begin
                stalled   = 1'b1;
                hold_data = sif.m_data_o;
                hold_chan = sif.m_chan_o;
                hold_last = sif.m_last_o;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.m_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", 64'(sif.m_valid_o), 64'd0);
        check("rst_last", 64'(sif.m_last_o), 64'd0);
        check("rst_chan", 64'(sif.m_chan_o), 64'd0);
        check("rst_data", 64'(sif.m_data_o), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);

        // 1: single frame, consumer always ready, one-cycle latency
        sif.m_ready_i = 1'b1;
        frame_valid = 1'b1;
        frame_data  = 32'h44332211;
        expect_frame(32'h44332211);
        tick();
        frame_valid = 1'b0;
        check("t1_level", 64'(level), 64'd1);
        check("t1_valid", 64'(sif.m_valid_o), 64'd1);
        check("t1_chan0", 64'(sif.m_chan_o), 64'd0);
        tick(); tick(); tick(); tick();
        check("t1_level_end", 64'(level), 64'd0);
        check("t1_valid_end", 64'(sif.m_valid_o), 64'd0);

        // 2: frame_valid held high for 6 cycles gives one push
        sif.m_ready_i = 1'b0;
        frame_valid = 1'b1;
        frame_data  = 32'hA4A3A2A1;
        expect_frame(32'hA4A3A2A1);
        repeat (6) tick();
        frame_valid = 1'b0;
        tick();
        check("t2_level", 64'(level), 64'd1);
        check("t2_drop", 64'(drop_count), 64'd0);
        drain("t2");

        // 3: five frames into a four-deep FIFO with the consumer stalled
        sif.m_ready_i = 1'b0;
        push_frame(32'h14131211, 1'b1);
        push_frame(32'h24232221, 1'b1);
        push_frame(32'h34333231, 1'b1);
        push_frame(32'h44434241, 1'b1);
        push_frame(32'h54535251, 1'b0);
        check("t3_level", 64'(level), 64'd4);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_drop", 64'(drop_count), 64'd1);

        // 4: push coincident with last-beat handshake while full
        sif.m_ready_i = 1'b1;
        tick(); tick(); tick();
        frame_valid = 1'b1;
        frame_data  = 32'h64636261;
        expect_frame(32'h64636261);
        tick();
        frame_valid = 1'b0;
        check("t4_level", 64'(level), 64'd4);
        check("t4_drop", 64'(drop_count), 64'd1);
        check("t4_chan", 64'(sif.m_chan_o), 64'd0);
        drain("t4");
        check("t4_level_end", 64'(level), 64'd0);

        // 5: toggling ready mid-frame, then random stall soak
        for (int i = 0; i < 2; i++) begin
            sif.m_ready_i = 1'b0;
            push_frame(32'h7D7C7B7A + 32'(i), 1'b1);
        end
        for (int i = 0; i < 20; i++) begin
            sif.m_ready_i = i[0];
            tick();
        end
        drain("t5a");
        for (int i = 0; i < 400; i++) begin
            sif.m_ready_i = 1'($urandom_range(0, 1));
            if (frame_valid) begin
                frame_valid = 1'b0;
            end else if (outstanding < 3 && $urandom_range(0, 2) == 0) begin
                frame_valid = 1'b1;
                frame_data  = $urandom;
                expect_frame(frame_data);
            end
            tick();
        end
        frame_valid = 1'b0;
        drain("t5b");
        check("t5_drop", 64'(drop_count), 64'd1);

        // 6: reset mid-stream with two frames held
        sif.m_ready_i = 1'b0;
        push_frame(32'h88878685, 1'b1);
        push_frame(32'h98979695, 1'b1);
        sif.m_ready_i = 1'b1;
        tick(); tick();
        sif.m_ready_i = 1'b0;
        check("t6_level_pre", 64'(level), 64'd2);
        rst = 1'b1;
        tick();
        exp_q.delete();
        outstanding = 0;
        rst = 1'b0;
        check("t6_valid", 64'(sif.m_valid_o), 64'd0);
        check("t6_level", 64'(level), 64'd0);
        check("t6_overflow", 64'(overflow), 64'd0);
        check("t6_drop", 64'(drop_count), 64'd0);
        check("t6_chan", 64'(sif.m_chan_o), 64'd0);

        // After reset a fresh frame streams normally
        push_frame(32'hC4C3C2C1, 1'b1);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
